// File: rtl/pwm_ctrl_pkg.sv
// Shared PWM control types and default constants.
package pwm_ctrl_pkg;

  localparam int unsigned PWM_PERIOD = 10;
  localparam int unsigned PWM_DUTY_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_step_timer.sv
// Counts PWM period-wrap pulses and flags the one that should move the duty.
module pwm_step_timer #(
  parameter int unsigned STEP_WAIT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  input  logic i_period_end,
  output logic o_step_tick_c
);

  localparam int unsigned CNT_W = (STEP_WAIT > 1) ? $clog2(STEP_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_WAIT - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Advance on qualifying pulses, wrap after the step pulse, clear on ramp entry.
  always_comb begin
    o_step_tick_c = 1'b0;
    wait_cnt_d    = wait_cnt_q;
    if (i_clear) begin
      wait_cnt_d = '0;
    end else if (i_en && i_period_end) begin
      if (wait_cnt_q == LAST) begin
        o_step_tick_c = 1'b1;
        wait_cnt_d    = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

  // Wait counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Ramps the PWM duty toward a target one step at a time, aligned to period wraps.
module pwm_duty_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD    = PWM_PERIOD,
  parameter int unsigned DUTY_W    = PWM_DUTY_W,
  parameter int unsigned STEP_WAIT = 2,
  parameter int unsigned INIT_DUTY = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_period_end,
  input  logic              i_inc,
  input  logic              i_dec,
  input  logic              i_tgt_valid,
  input  logic [DUTY_W-1:0] i_tgt,
  output logic              o_tgt_ready,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] INIT_V   = DUTY_W'(INIT_DUTY);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              err_q, err_d;
  logic              load_c;
  logic              step_tick_c;
  logic              timer_clear_c;
  logic [DUTY_W-1:0] step_duty_c;

  // Target update: a load beats inc/dec; inc/dec saturate at the legal range.
  always_comb begin
    tgt_d  = tgt_q;
    err_d  = 1'b0;
    load_c = i_tgt_valid && (state_q == IDLE);
    if (load_c) begin
      if (i_tgt <= PERIOD_V) begin
        tgt_d = i_tgt;
      end else begin
        err_d = 1'b1;
      end
    end else if (i_inc && !i_dec) begin
      if (tgt_q < PERIOD_V) begin
        tgt_d = tgt_q + DUTY_W'(1);
      end
    end else if (i_dec && !i_inc) begin
      if (tgt_q != '0) begin
        tgt_d = tgt_q - DUTY_W'(1);
      end
    end
  end

  // Ramp FSM: equality check first, then one step per timer tick toward target.
  always_comb begin
    state_d       = state_q;
    duty_d        = duty_q;
    timer_clear_c = 1'b0;
    step_duty_c   = (tgt_q > duty_q) ? (duty_q + DUTY_W'(1)) : (duty_q - DUTY_W'(1));
    case (state_q)
      IDLE: begin
        if (tgt_q != duty_q) begin
          state_d       = RAMP;
          timer_clear_c = 1'b1;
        end
      end
      RAMP: begin
        if (tgt_q == duty_q) begin
          state_d = IDLE;
        end else if (step_tick_c) begin
          duty_d = step_duty_c;
          if (step_duty_c == tgt_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, target, duty and error registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      tgt_q   <= INIT_V;
      duty_q  <= INIT_V;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      err_q   <= err_d;
    end
  end

  pwm_step_timer #(
    .STEP_WAIT(STEP_WAIT)
  ) u_step_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (timer_clear_c),
    .i_en         (state_q == RAMP),
    .i_period_end (i_period_end),
    .o_step_tick_c(step_tick_c)
  );

  assign o_tgt_ready = (state_q == IDLE);
  assign o_busy      = (state_q == RAMP);
  assign o_duty      = duty_q;
  assign o_err       = err_q;

endmodule
